// File: rtl/mdu_pkg.sv
// Shared types and operation-decode helpers for the iterative multiply/divide unit.
// The op encoding matches the RV M-extension funct3 field.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIX,
    DONE
  } mdu_state_e;

  function automatic logic is_div(input mdu_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(input mdu_op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_signed1(input mdu_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed2(input mdu_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration on the {hi,lo} working pair: right-shifting shift-add for
// multiply, left-shifting restoring shift-subtract for divide.
module mdu_step #(
  parameter int XLEN = 32
) (
  input  logic            i_div,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_shl;
  logic [XLEN:0] w_diff;

  assign w_sum  = {1'b0, i_hi} + {1'b0, i_b};
  assign w_shl  = {i_hi, i_lo[XLEN-1]};
  assign w_diff = w_shl - {1'b0, i_b};

  // Divide relies on hi < b, so the top bit of w_diff is a clean borrow flag.
  always_comb begin
    o_hi = i_hi;
    o_lo = i_lo;
    if (i_div) begin
      if (!w_diff[XLEN]) begin
        o_hi = w_diff[XLEN-1:0];
        o_lo = {i_lo[XLEN-2:0], 1'b1};
      end else begin
        o_hi = w_shl[XLEN-1:0];
        o_lo = {i_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      if (i_lo[0]) begin
        {o_hi, o_lo} = {w_sum, i_lo[XLEN-1:1]};
      end else begin
        {o_hi, o_lo} = {1'b0, i_hi, i_lo[XLEN-1:1]};
      end
    end
  end

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit: operands in on one valid/ready handshake,
// result out on a second; i_kill aborts an in-flight op on pipeline flush.
//
// state | meaning
// IDLE  | o_ready=1, waiting for a request
// BUSY  | XLEN radix-2 iterations, counter XLEN-1 down to 0
// FIX   | sign correction / special-case value, register o_result
// DONE  | o_valid=1, hold result until i_ready
module mdu #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  input  logic            i_kill,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result
);
  import mdu_pkg::*;

  localparam int CW = $clog2(XLEN);

  mdu_state_e        r_state;
  mdu_state_e        w_state_nxt;
  logic [CW-1:0]     r_cnt;
  mdu_op_e           r_op;
  logic              r_special;
  logic              r_neg_res;
  logic              r_neg_rem;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_result;

  mdu_op_e           w_op;
  logic              w_accept;
  logic              w_s1;
  logic              w_s2;
  logic              w_div0;
  logic              w_ovf;
  logic              w_is_div;
  logic [XLEN-1:0]   w_abs1;
  logic [XLEN-1:0]   w_abs2;
  logic [XLEN-1:0]   w_min;
  logic [XLEN-1:0]   w_step_hi;
  logic [XLEN-1:0]   w_step_lo;
  logic [XLEN-1:0]   w_fix;
  logic [2*XLEN-1:0] w_prod;

  assign w_op     = mdu_op_e'(i_op);
  assign w_accept = i_valid && (r_state == IDLE) && !i_kill;
  assign w_min    = {1'b1, {(XLEN-1){1'b0}}};
  assign w_s1     = is_signed1(w_op) && i_op1[XLEN-1];
  assign w_s2     = is_signed2(w_op) && i_op2[XLEN-1];
  assign w_abs1   = w_s1 ? -i_op1 : i_op1;
  assign w_abs2   = w_s2 ? -i_op2 : i_op2;
  assign w_div0   = is_div(w_op) && (i_op2 == '0);
  assign w_ovf    = is_div(w_op) && is_signed2(w_op) && (i_op1 == w_min) && (i_op2 == '1);
  assign w_is_div = is_div(r_op);
  assign o_result = r_result;

  mdu_step #(.XLEN(XLEN)) u_step (
    .i_div (w_is_div),
    .i_hi  (r_hi),
    .i_lo  (r_lo),
    .i_b   (r_b),
    .o_hi  (w_step_hi),
    .o_lo  (w_step_lo)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_ready     = 1'b0;
    o_valid     = 1'b0;
    case (r_state)
      IDLE: begin
        o_ready = 1'b1;
        if (w_accept) w_state_nxt = (w_div0 || w_ovf) ? FIX : BUSY;
      end
      BUSY: begin
        if (i_kill)              w_state_nxt = IDLE;
        else if (r_cnt == '0)    w_state_nxt = FIX;
      end
      FIX: begin
        w_state_nxt = i_kill ? IDLE : DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_kill || i_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Special cases park their final value in r_lo so FIX only has to select it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_op      <= OP_MUL;
      r_special <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_b       <= '0;
      r_result  <= '0;
    end else if (w_accept) begin
      r_op      <= w_op;
      r_cnt     <= CW'(XLEN-1);
      r_special <= w_div0 || w_ovf;
      r_neg_res <= w_s1 ^ w_s2;
      r_neg_rem <= w_s1;
      r_hi      <= '0;
      if (w_div0) begin
        r_lo <= is_rem(w_op) ? i_op1 : '1;
      end else if (w_ovf) begin
        r_lo <= is_rem(w_op) ? '0 : w_min;
      end else if (is_div(w_op)) begin
        r_lo <= w_abs1;
        r_b  <= w_abs2;
      end else begin
        r_lo <= w_abs2;
        r_b  <= w_abs1;
      end
    end else if (r_state == BUSY) begin
      r_hi <= w_step_hi;
      r_lo <= w_step_lo;
      if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
    end else if (r_state == FIX && !i_kill) begin
      r_result <= w_fix;
    end
  end

  always_comb begin
    w_prod = {r_hi, r_lo};
    if (r_neg_res) w_prod = -w_prod;
    w_fix = '0;
    if (r_special) begin
      w_fix = r_lo;
    end else begin
      case (r_op)
        OP_MUL:                       w_fix = w_prod[XLEN-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: w_fix = w_prod[2*XLEN-1:XLEN];
        OP_DIV, OP_DIVU:              w_fix = r_neg_res ? -r_lo : r_lo;
        default:                      w_fix = r_neg_rem ? -r_hi : r_hi;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: arithmetic results, latency, backpressure, kill and reset.
module tb_mdu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_kill = 1'b0;
  logic        i_ready = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] op1 = 32'h0;
  logic [31:0] op2 = 32'h0;
  logic        o_ready;
  logic        o_valid;
  logic [31:0] o_result;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mdu #(.XLEN(32)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op     (op),
    .i_op1    (op1),
    .i_op2    (op2),
    .i_kill   (i_kill),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    i_valid = 1'b1; op = f; op1 = a; op2 = b;
    step();
    i_valid = 1'b0; op = 3'b000; op1 = 32'hDEADBEEF; op2 = 32'hDEADBEEF;
  endtask

  task automatic wait_valid(output int lat, output int rdy_hi);
    lat = 0;
    rdy_hi = 0;
    while (!o_valid && lat < 100) begin
      if (o_ready) rdy_hi++;
      step();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat, rdy_hi;
    chk({tag, " ready"}, 32'(o_ready), 32'd1);
    start(f, a, b);
    wait_valid(lat, rdy_hi);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " ready_busy"}, 32'(rdy_hi), 32'd0);
    chk({tag, " result"}, o_result, exp);
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    chk({tag, " valid_drop"}, 32'(o_valid), 32'd0);
  endtask

  task automatic watch_quiet(input string tag);
    int vhi = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_valid) vhi++;
      step();
    end
    chk({tag, " never_valid"}, 32'(vhi), 32'd0);
  endtask

  initial begin
    int lat, rdy_hi;
    step();
    step();
    chk("rst valid", 32'(o_valid), 32'd0);
    chk("rst ready", 32'(o_ready), 32'd1);
    chk("rst result", o_result, 32'h0);
    rst_n = 1'b1;
    step();

    run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
    run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op("remu",   3'b111, 32'd10,       32'd3,        32'd1,        33);
    run_op("div0",   3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("rem0",   3'b110, 32'd5,        32'd0,        32'd5,        1);
    run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

    // Backpressure: result held while i_ready stays low, competing request ignored.
    start(3'b101, 32'hFFFFFFFE, 32'd2);
    wait_valid(lat, rdy_hi);
    chk("bp latency", 32'(lat), 32'd33);
    chk("bp result", o_result, 32'h7FFFFFFF);
    i_valid = 1'b1; op = 3'b000; op1 = 32'd3; op2 = 32'd4;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp hold valid", 32'(o_valid), 32'd1);
      chk("bp hold result", o_result, 32'h7FFFFFFF);
      chk("bp hold ready", 32'(o_ready), 32'd0);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    chk("bp release valid", 32'(o_valid), 32'd0);
    chk("bp release ready", 32'(o_ready), 32'd1);

    // Kill on the 10th BUSY cycle.
    start(3'b000, 32'd5, 32'd6);
    repeat (9) step();
    chk("kill busy ready", 32'(o_ready), 32'd0);
    i_kill = 1'b1;
    step();
    i_kill = 1'b0;
    chk("kill ready", 32'(o_ready), 32'd1);
    chk("kill valid", 32'(o_valid), 32'd0);
    watch_quiet("kill");

    // Kill wins over a request presented in IDLE.
    i_valid = 1'b1; i_kill = 1'b1; op = 3'b000; op1 = 32'd2; op2 = 32'd2;
    step();
    i_valid = 1'b0; i_kill = 1'b0;
    chk("kill idle ready", 32'(o_ready), 32'd1);

    // Synchronous reset mid-op.
    start(3'b100, 32'd100, 32'd7);
    repeat (5) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst ready", 32'(o_ready), 32'd1);
    chk("midrst valid", 32'(o_valid), 32'd0);
    chk("midrst result", o_result, 32'h0);
    watch_quiet("midrst");

    run_op("mul_after", 3'b000, 32'd3, 32'd4, 32'd12, 33);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
